byte_load_pacer: RTL and testbench

- Upstream feeder for the 8-bit enable-and-reset output registers. It produces the register's next-value bus (q_next) and its load enable (en).
- Accepts bytes from a producer over a valid/ready handshake and buffers them in a small FIFO.
- Issues one single-cycle load strobe per byte, with loads spaced at least DIV clock cycles apart, so the downstream register captures each byte exactly once.

---
 rtl/byte_load_pacer_pkg.sv | 24 ++
 rtl/byte_load_pacer_if.sv | 25 ++
 rtl/byte_fifo_sync.sv | 50 +++++
 rtl/byte_load_pacer.sv | 111 +++++++++++
 tb/tb_byte_load_pacer.sv | 261 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/byte_load_pacer_pkg.sv
// Shared types and constants for the byte load pacer.
// Holds the FSM encoding, default widths and a clog2 helper.
package byte_load_pacer_pkg;

    localparam int DW_DEF    = 8;
    localparam int DEPTH_DEF = 4;
    localparam int DIV_DEF   = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_GAP  = 2'd2
    } state_t;

    function automatic int clog2(input int v);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < v) r = i + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/byte_load_pacer_if.sv
// Producer-side handshake and register-load bus of the byte load pacer.
// The pacer uses the slave modport; the producer/observer side uses master.
interface byte_load_pacer_if #(
    parameter int DW = 8,
    parameter int AW = 2
);
    logic          flush;
    logic          in_valid;
    logic [DW-1:0] in_data;
    logic          in_ready;
    logic          en;
    logic [DW-1:0] q_next;
    logic [AW:0]   count;
    logic          busy;

    modport master (
        output flush, in_valid, in_data,
        input  in_ready, en, q_next, count, busy
    );

    modport slave (
        input  flush, in_valid, in_data,
        output in_ready, en, q_next, count, busy
    );
endinterface

// File: rtl/byte_fifo_sync.sv
// Purpose: circular byte buffer with wrapping pointers and occupancy count.
// Latency: write visible at head one cycle after the write edge; rdata is the head combinationally.
// Backpressure: writes when full and reads when empty are ignored; clr empties the buffer.
module byte_fifo_sync #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clr,
    input  logic          wr,
    input  logic          rd,
    input  logic [DW-1:0] wdata,
    output logic [DW-1:0] rdata,
    output logic [AW:0]   count,
    output logic          full,
    output logic          empty
);
    localparam int DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    logic [AW-1:0] wp;
    logic [AW-1:0] rp;
    logic          wr_ok;
    logic          rd_ok;

    assign full  = (count == (AW+1)'(DEPTH));
    assign empty = (count == '0);
    assign wr_ok = wr && !full;
    assign rd_ok = rd && !empty;
    assign rdata = mem[rp];

    always_ff @(posedge clk) begin
        if (!reset || clr) begin
            wp    <= '0;
            rp    <= '0;
            count <= '0;
        end else begin
            if (wr_ok) wp <= wp + AW'(1);
            if (rd_ok) rp <= rp + AW'(1);
            if (wr_ok && !rd_ok)      count <= count + (AW+1)'(1);
            else if (rd_ok && !wr_ok) count <= count - (AW+1)'(1);
        end
    end

    // Storage is not reset; only entries between the pointers are ever read.
    always_ff @(posedge clk) begin
        if (wr_ok) mem[wp] <= wdata;
    end
endmodule

// File: rtl/byte_load_pacer.sv
// Purpose: buffers producer bytes and emits one paced load strobe (en) per byte with q_next.
// Latency: a byte accepted into an empty, idle block is strobed one cycle after acceptance.
// Backpressure: in_ready drops when the FIFO is full, during flush and while reset is low.
module byte_load_pacer
    import byte_load_pacer_pkg::*;
#(
    parameter int DW    = DW_DEF,
    parameter int DEPTH = DEPTH_DEF,
    parameter int AW    = clog2(DEPTH),
    parameter int DIV   = DIV_DEF
) (
    input  logic clk,
    input  logic reset,
    byte_load_pacer_if.slave bus
);
    localparam int PW = clog2(DIV) + 1;

    state_t        state;
    state_t        state_n;
    logic [PW-1:0] pacer;
    logic          issue;
    logic          rd;
    logic          wr;
    logic          full;
    logic          empty;
    logic [DW-1:0] head;
    logic [AW:0]   cnt;
    logic          en_q;
    logic [DW-1:0] q_q;

    assign bus.in_ready = !full && !bus.flush && reset;
    assign wr           = bus.in_valid && bus.in_ready;
    assign rd           = issue && !bus.flush;

    byte_fifo_sync #(
        .DW (DW),
        .AW (AW)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clr   (bus.flush),
        .wr    (wr),
        .rd    (rd),
        .wdata (bus.in_data),
        .rdata (head),
        .count (cnt),
        .full  (full),
        .empty (empty)
    );

    always_comb begin
        state_n = state;
        issue   = 1'b0;
        case (state)
            ST_IDLE: begin
                if (!empty) begin
                    issue   = 1'b1;
                    state_n = ST_LOAD;
                end
            end
            ST_LOAD: begin
                // With DIV=1 there is no gap: loads may run back to back.
                if (DIV == 1) begin
                    if (!empty) issue   = 1'b1;
                    else        state_n = ST_IDLE;
                end else begin
                    state_n = ST_GAP;
                end
            end
            ST_GAP: begin
                if (pacer <= PW'(1)) begin
                    if (!empty) begin
                        issue   = 1'b1;
                        state_n = ST_LOAD;
                    end else begin
                        state_n = ST_IDLE;
                    end
                end
            end
            default: state_n = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state <= ST_IDLE;
            pacer <= '0;
            en_q  <= 1'b0;
            q_q   <= '0;
        end else if (bus.flush) begin
            state <= ST_IDLE;
            pacer <= '0;
            en_q  <= 1'b0;
        end else begin
            state <= state_n;
            en_q  <= issue;
            if (issue) begin
                q_q   <= head;
                pacer <= PW'(DIV - 1);
            end else if (state == ST_GAP && pacer != '0) begin
                // Pacer only counts in GAP so the LOAD cycle is part of the spacing.
                pacer <= pacer - PW'(1);
            end
        end
    end

    assign bus.en     = en_q;
    assign bus.q_next = q_q;
    assign bus.count  = cnt;
    assign bus.busy   = (cnt != '0) || (state != ST_IDLE);
endmodule

// File: tb/tb_byte_load_pacer.sv
// Bench for byte_load_pacer: DIV=4 and DIV=1 instances against a queue/next-load-time model.
module tb_byte_load_pacer;
    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    byte_load_pacer_if #(.DW(8), .AW(2)) if0 ();
    byte_load_pacer_if #(.DW(8), .AW(2)) if1 ();

    byte_load_pacer #(.DW(8), .DEPTH(4), .DIV(4)) dut0 (.clk(clk), .reset(rst), .bus(if0));
    byte_load_pacer #(.DW(8), .DEPTH(4), .DIV(1)) dut1 (.clk(clk), .reset(rst), .bus(if1));

    int nchk = 0;
    int nerr = 0;
    int cyc  = 0;
    logic chk_on = 1'b0;

    // Model: FIFO contents as an array window plus the earliest cycle the next load may issue.
    logic [7:0] mbuf [2][64];
    int         mhead [2] = '{0, 0};
    int         mtail [2] = '{0, 0};
    int         mnext [2] = '{0, 0};
    logic       men   [2] = '{1'b0, 1'b0};
    logic [7:0] mq    [2] = '{8'h00, 8'h00};
    logic       macc  [2] = '{1'b0, 1'b0};

    int         lc0 [$];
    logic [7:0] ld0 [$];
    int         lc1 [$];
    logic [7:0] ld1 [$];
    int         mx0 = 0;

    int off2 [4] = '{1, 5, 9, 13};
    logic [7:0] dat5 [4] = '{8'h11, 8'h22, 8'h33, 8'h44};

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s at cycle %0d: actual=%0h required=%0h", nm, cyc, act, exp);
        end
    endtask

    task automatic mstep(input int i, input int div, input logic fl, input logic iv, input logic [7:0] id);
        int sz;
        sz = mtail[i] - mhead[i];
        macc[i] = 1'b0;
        if (!rst) begin
            mhead[i] = 0; mtail[i] = 0; mnext[i] = 0; men[i] = 1'b0; mq[i] = 8'h00;
        end else if (fl) begin
            mhead[i] = mtail[i]; mnext[i] = 0; men[i] = 1'b0;
        end else begin
            men[i] = 1'b0;
            if (sz > 0 && cyc >= mnext[i]) begin
                men[i]   = 1'b1;
                mq[i]    = mbuf[i][mhead[i] & 63];
                mhead[i] = mhead[i] + 1;
                mnext[i] = cyc + div;
            end
            if (iv && sz != 4) begin
                mbuf[i][mtail[i] & 63] = id;
                mtail[i] = mtail[i] + 1;
                macc[i]  = 1'b1;
            end
        end
    endtask

    task automatic cmp_inst(input int i, input logic en, input logic [7:0] q, input logic [2:0] cnt,
                            input logic rdy, input logic bsy, input logic fl);
        int sz;
        sz = mtail[i] - mhead[i];
        chk($sformatf("en[%0d]", i),       32'(en),  32'(men[i]));
        chk($sformatf("q_next[%0d]", i),   32'(q),   32'(mq[i]));
        chk($sformatf("count[%0d]", i),    32'(cnt), 32'(sz));
        chk($sformatf("in_ready[%0d]", i), 32'(rdy), 32'(rst && !fl && sz != 4));
        chk($sformatf("busy[%0d]", i),     32'(bsy), 32'(sz != 0 || cyc < mnext[i]));
    endtask

    initial forever begin
        @(posedge clk);
        cyc = cyc + 1;
        mstep(0, 4, if0.flush, if0.in_valid, if0.in_data);
        mstep(1, 1, if1.flush, if1.in_valid, if1.in_data);
    end

    initial forever begin
        @(posedge clk);
        #2;
        if (chk_on) begin
            cmp_inst(0, if0.en, if0.q_next, if0.count, if0.in_ready, if0.busy, if0.flush);
            cmp_inst(1, if1.en, if1.q_next, if1.count, if1.in_ready, if1.busy, if1.flush);
            if (if0.en === 1'b1) begin lc0.push_back(cyc); ld0.push_back(if0.q_next); end
            if (if1.en === 1'b1) begin lc1.push_back(cyc); ld1.push_back(if1.q_next); end
            if (int'(if0.count) > mx0) mx0 = int'(if0.count);
        end
    end

    task automatic wait_idle(input string nm);
        int n;
        n = 0;
        while ((if0.busy !== 1'b0 || if1.busy !== 1'b0) && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (n >= 200) begin
            nchk++; nerr++;
            $display("FAIL %s_idle_timeout: busy still high after %0d cycles", nm, n);
        end
        repeat (2) @(negedge clk);
    endtask

    initial begin
        int t0;
        int v;
        int it;
        if0.flush = 1'b0; if0.in_valid = 1'b0; if0.in_data = 8'h00;
        if1.flush = 1'b0; if1.in_valid = 1'b0; if1.in_data = 8'h00;

        // Reset state
        repeat (3) @(negedge clk);
        chk_on = 1'b1;
        chk("rst_en",       32'(if0.en),       32'd0);
        chk("rst_q_next",   32'(if0.q_next),   32'd0);
        chk("rst_count",    32'(if0.count),    32'd0);
        chk("rst_busy",     32'(if0.busy),     32'd0);
        chk("rst_in_ready", 32'(if0.in_ready), 32'd0);
        rst = 1'b1;
        #1;
        chk("rel_in_ready", 32'(if0.in_ready), 32'd1);
        repeat (2) @(negedge clk);

        // Single byte
        lc0.delete(); ld0.delete();
        @(negedge clk);
        t0 = cyc + 1;
        if0.in_valid = 1'b1; if0.in_data = 8'hA5;
        @(negedge clk);
        if0.in_valid = 1'b0; if0.in_data = 8'h00;
        repeat (6) @(negedge clk);
        chk("t1_nloads", 32'(lc0.size()), 32'd1);
        if (lc0.size() == 1) begin
            chk("t1_offset", 32'(lc0[0] - t0), 32'd1);
            chk("t1_data",   32'(ld0[0]),      32'hA5);
        end
        chk("t1_busy",   32'(if0.busy),   32'd0);
        chk("t1_count",  32'(if0.count),  32'd0);
        chk("t1_q_hold", 32'(if0.q_next), 32'hA5);

        // Paced burst of four
        lc0.delete(); ld0.delete(); mx0 = 0;
        @(negedge clk);
        t0 = cyc + 1;
        for (int k = 1; k <= 4; k++) begin
            if0.in_valid = 1'b1; if0.in_data = 8'(k);
            @(negedge clk);
        end
        if0.in_valid = 1'b0;
        wait_idle("t2");
        chk("t2_nloads", 32'(lc0.size()), 32'd4);
        if (lc0.size() == 4) begin
            for (int k = 0; k < 4; k++) begin
                chk($sformatf("t2_offset%0d", k), 32'(lc0[k] - t0), 32'(off2[k]));
                chk($sformatf("t2_data%0d", k),   32'(ld0[k]),      32'(k + 1));
            end
        end
        chk("t2_peak_count", 32'(mx0), 32'd3);

        // Back-pressure and pointer wrap
        lc0.delete(); ld0.delete(); mx0 = 0; v = 1; it = 0;
        while (v <= 12 && it < 200) begin
            @(negedge clk);
            if0.in_valid = 1'b1; if0.in_data = 8'(v);
            @(posedge clk);
            #1;
            if (macc[0]) v++;
            it++;
        end
        @(negedge clk);
        if0.in_valid = 1'b0;
        wait_idle("t3");
        chk("t3_offers",     32'(it),         32'd31);
        chk("t3_peak_count", 32'(mx0),        32'd4);
        chk("t3_nloads",     32'(lc0.size()), 32'd12);
        if (lc0.size() == 12) begin
            for (int k = 0; k < 12; k++) chk($sformatf("t3_data%0d", k), 32'(ld0[k]), 32'(k + 1));
        end

        // DIV=1 streaming
        lc1.delete(); ld1.delete(); v = 1; it = 0;
        @(negedge clk);
        t0 = cyc + 1;
        while (v <= 8 && it < 50) begin
            if1.in_valid = 1'b1; if1.in_data = 8'(v);
            @(posedge clk);
            #1;
            if (macc[1]) v++;
            it++;
            @(negedge clk);
        end
        if1.in_valid = 1'b0;
        wait_idle("t4");
        chk("t4_offers", 32'(it),         32'd8);
        chk("t4_nloads", 32'(lc1.size()), 32'd8);
        if (lc1.size() == 8) begin
            for (int k = 0; k < 8; k++) begin
                chk($sformatf("t4_cycle%0d", k), 32'(lc1[k] - t0), 32'(k + 1));
                chk($sformatf("t4_data%0d", k),  32'(ld1[k]),      32'(k + 1));
            end
        end

        // Flush mid-burst with a competing write
        lc0.delete(); ld0.delete();
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if0.in_valid = 1'b1; if0.in_data = dat5[k];
            @(negedge clk);
        end
        if0.flush = 1'b1; if0.in_valid = 1'b1; if0.in_data = 8'h77;
        @(posedge clk);
        #3;
        chk("t5_count",  32'(if0.count),  32'd0);
        chk("t5_en",     32'(if0.en),     32'd0);
        chk("t5_q_hold", 32'(if0.q_next), 32'h11);
        chk("t5_busy",   32'(if0.busy),   32'd0);
        @(negedge clk);
        if0.flush = 1'b0; if0.in_valid = 1'b0; if0.in_data = 8'h00;
        repeat (8) @(negedge clk);
        chk("t5_nloads", 32'(lc0.size()), 32'd1);
        if (lc0.size() == 1) chk("t5_only_first", 32'(ld0[0]), 32'h11);
        chk("t5_count_after", 32'(if0.count), 32'd0);

        // Reset on the edge where the strobe would rise
        lc0.delete(); ld0.delete();
        @(negedge clk);
        if0.in_valid = 1'b1; if0.in_data = 8'h5A;
        @(negedge clk);
        if0.in_valid = 1'b0; if0.in_data = 8'h00; rst = 1'b0;
        @(posedge clk);
        #3;
        chk("t6_en",       32'(if0.en),       32'd0);
        chk("t6_q_next",   32'(if0.q_next),   32'd0);
        chk("t6_count",    32'(if0.count),    32'd0);
        chk("t6_in_ready", 32'(if0.in_ready), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk("t6_rel_in_ready", 32'(if0.in_ready), 32'd1);
        repeat (6) @(negedge clk);
        chk("t6_nloads", 32'(lc0.size()), 32'd0);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("Result: errors=%0d of %0d checks", nerr + 1, nchk + 1);
        $fatal(1, "watchdog expired");
    end
endmodule
